// File: rtl/stream_mux_n_1_if.sv
// stream_mux_n_1_if: N input valid/ready channels plus one registered output stream
interface stream_mux_n_1_if #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = 2
);
   logic [NUM_IN*WIDTH-1:0] in_data;
   logic [NUM_IN-1:0]       in_valid;
   logic [NUM_IN-1:0]       in_ready;
   logic [SEL_W-1:0]        sel;
   logic [WIDTH-1:0]        out_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [SEL_W-1:0]        out_src;
   logic [31:0]             xfer_count;
   modport slave (
      input  in_data, in_valid, sel, out_ready,
      output in_ready, out_data, out_valid, out_src, xfer_count
   );
   modport master (
      output in_data, in_valid, sel, out_ready,
      input  in_ready, out_data, out_valid, out_src, xfer_count
   );
endinterface

// File: rtl/stream_mux_n_1.sv
// stream_mux_n_1: registered N:1 valid/ready multiplexer with external-select or round-robin grant
module stream_mux_n_1 #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = 2,
   parameter int MODE   = 0
) (
   input logic             clk,
   input logic             reset,
   stream_mux_n_1_if.slave bus
);
   localparam int SEL_N = 2 ** SEL_W;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SEL_W-1:0] out_src_q, out_src_d, ptr_q, ptr_d, rr_grant, grant;
   logic             out_valid_q, out_valid_d;
   logic [31:0]      xfer_count_q, xfer_count_d;
   logic [SEL_N-1:0] valid_ext;
   logic             sel_ok, load_en, grant_valid, xfer;
   // valid vector padded to the full select range so an out-of-range sel reads a zero
   assign valid_ext   = SEL_N'(bus.in_valid);
   assign sel_ok      = int'(bus.sel) < NUM_IN;
   assign load_en     = !out_valid_q || bus.out_ready;
   assign grant       = MODE == 1 ? rr_grant : (sel_ok ? bus.sel : '0);
   assign grant_valid = MODE == 1 ? |bus.in_valid : sel_ok && valid_ext[bus.sel];
   assign xfer        = !reset && load_en && grant_valid;
   assign bus.in_ready   = xfer ? NUM_IN'(1) << grant : '0;
   assign bus.out_data   = out_data_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_src    = out_src_q;
   assign bus.xfer_count = xfer_count_q;
   // round-robin: scan from the pointer downwards in priority so the lowest offset wins
   always_comb begin
      rr_grant = '0;
      for (int k = NUM_IN - 1; k >= 0; k--)
         if (bus.in_valid[(int'(ptr_q) + k) % NUM_IN]) rr_grant = SEL_W'((int'(ptr_q) + k) % NUM_IN);
   end
   // next state: refill/empty the output stage whenever it can load, hold on stall
   always_comb begin
      out_data_d   = out_data_q;
      out_src_d    = out_src_q;
      out_valid_d  = load_en ? xfer : out_valid_q;
      xfer_count_d = xfer_count_q;
      ptr_d        = ptr_q;
      if (xfer) begin
         out_data_d   = bus.in_data[int'(grant)*WIDTH +: WIDTH];
         out_src_d    = grant;
         xfer_count_d = xfer_count_q + 32'd1;
         ptr_d        = MODE == 1 ? (int'(grant) == NUM_IN - 1 ? '0 : grant + 1'b1) : ptr_q;
      end
   end
   // state register; reset discards any buffered beat
   always_ff @(posedge clk) begin
      if (reset) begin
         out_data_q   <= '0;
         out_src_q    <= '0;
         out_valid_q  <= 1'b0;
         xfer_count_q <= '0;
         ptr_q        <= '0;
      end else begin
         out_data_q   <= out_data_d;
         out_src_q    <= out_src_d;
         out_valid_q  <= out_valid_d;
         xfer_count_q <= xfer_count_d;
         ptr_q        <= ptr_d;
      end
   end
endmodule

// File: tb/tb_stream_mux_n_1.sv
// tb_stream_mux_n_1: scoreboard bench for select-mode, round-robin and 3-input variants
module tb_stream_mux_n_1;
   typedef struct {
      logic [31:0] d;
      int          s;
      int          c;
   } exp_t;
   logic clk = 1'b0;
   logic reset;
   int n_tests = 0;
   int n_fail  = 0;
   int cnt0 = 0, cnt1 = 0, cnt2 = 0;
   exp_t q0[$], q1[$], q2[$];
   logic [31:0] d0[4], d1[4], d2[3];
   always #5 clk = ~clk;
   stream_mux_n_1_if #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) b0();
   stream_mux_n_1_if #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) b1();
   stream_mux_n_1_if #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) b2();
   stream_mux_n_1 #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .MODE(0)) u0 (.clk(clk), .reset(reset), .bus(b0));
   stream_mux_n_1 #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .MODE(1)) u1 (.clk(clk), .reset(reset), .bus(b1));
   stream_mux_n_1 #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .MODE(0)) u2 (.clk(clk), .reset(reset), .bus(b2));
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask
   function automatic int oh2i(input logic [3:0] oh);
      int r = 0;
      for (int i = 0; i < 4; i++) if (oh[i]) r = i;
      return r;
   endfunction
   task automatic step0(input logic [1:0] s, input logic [3:0] v, input logic r, input logic [3:0] er);
      @(posedge clk); #2;
      reset = 1'b0;
      b0.sel = s; b0.in_valid = v; b0.out_ready = r;
      for (int i = 0; i < 4; i++) b0.in_data[i*32 +: 32] = d0[i];
      #1;
      chk("u0 in_ready", 32'(b0.in_ready), 32'(er));
      if (er != 0) begin
         cnt0++;
         q0.push_back('{d0[oh2i(er)], oh2i(er), cnt0});
      end
   endtask
   task automatic step1(input logic [3:0] v, input logic r, input logic [3:0] er);
      @(posedge clk); #2;
      reset = 1'b0;
      b1.in_valid = v; b1.out_ready = r;
      for (int i = 0; i < 4; i++) b1.in_data[i*32 +: 32] = d1[i];
      #1;
      chk("u1 in_ready", 32'(b1.in_ready), 32'(er));
      if (er != 0) begin
         cnt1++;
         q1.push_back('{d1[oh2i(er)], oh2i(er), cnt1});
      end
   endtask
   task automatic step2(input logic [1:0] s, input logic [2:0] v, input logic r, input logic [2:0] er);
      @(posedge clk); #2;
      reset = 1'b0;
      b2.sel = s; b2.in_valid = v; b2.out_ready = r;
      for (int i = 0; i < 3; i++) b2.in_data[i*32 +: 32] = d2[i];
      #1;
      chk("u2 in_ready", 32'(b2.in_ready), 32'(er));
      if (er != 0) begin
         cnt2++;
         q2.push_back('{d2[oh2i({1'b0, er})], oh2i({1'b0, er}), cnt2});
      end
   endtask
   always @(negedge clk) if (!reset && b0.out_valid && b0.out_ready) begin
      exp_t e;
      if (q0.size() == 0) begin
         n_tests++; n_fail++;
         $display("FAIL u0 beat: unexpected beat data %0h, none required", b0.out_data);
      end else begin
         e = q0.pop_front();
         chk("u0 out_data", b0.out_data, e.d);
         chk("u0 out_src", 32'(b0.out_src), 32'(e.s));
         chk("u0 xfer_count", b0.xfer_count, 32'(e.c));
      end
   end
   always @(negedge clk) if (!reset && b1.out_valid && b1.out_ready) begin
      exp_t e;
      if (q1.size() == 0) begin
         n_tests++; n_fail++;
         $display("FAIL u1 beat: unexpected beat data %0h, none required", b1.out_data);
      end else begin
         e = q1.pop_front();
         chk("u1 out_data", b1.out_data, e.d);
         chk("u1 out_src", 32'(b1.out_src), 32'(e.s));
         chk("u1 xfer_count", b1.xfer_count, 32'(e.c));
      end
   end
   always @(negedge clk) if (!reset && b2.out_valid && b2.out_ready) begin
      exp_t e;
      if (q2.size() == 0) begin
         n_tests++; n_fail++;
         $display("FAIL u2 beat: unexpected beat data %0h, none required", b2.out_data);
      end else begin
         e = q2.pop_front();
         chk("u2 out_data", b2.out_data, e.d);
         chk("u2 out_src", 32'(b2.out_src), 32'(e.s));
         chk("u2 xfer_count", b2.xfer_count, 32'(e.c));
      end
   end
   initial begin
      reset = 1'b1;
      b0.sel = '0; b0.in_valid = '0; b0.out_ready = 1'b1; b0.in_data = '0;
      b1.sel = '0; b1.in_valid = 4'hF; b1.out_ready = 1'b1; b1.in_data = '0;
      b2.sel = '0; b2.in_valid = '0; b2.out_ready = 1'b1; b2.in_data = '0;
      d0 = '{32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
      d1 = '{32'd10, 32'd11, 32'd12, 32'd13};
      d2 = '{32'h0, 32'h0, 32'h77};
      repeat (2) @(posedge clk);
      #3;
      chk("rst u1 in_ready", 32'(b1.in_ready), 32'h0);
      chk("rst u0 out_valid", 32'(b0.out_valid), 32'h0);
      chk("rst u0 out_data", b0.out_data, 32'h0);
      chk("rst u0 out_src", 32'(b0.out_src), 32'h0);
      chk("rst u0 xfer_count", b0.xfer_count, 32'h0);
      chk("rst u1 out_valid", 32'(b1.out_valid), 32'h0);
      b1.in_valid = '0;
      step0(2'd2, 4'b0100, 1'b1, 4'b0100);
      step0(2'd1, 4'b1101, 1'b1, 4'b0000);
      chk("u0 valid after accept", 32'(b0.out_valid), 32'h1);
      step0(2'd1, 4'b1101, 1'b1, 4'b0000);
      chk("u0 valid drop no grant", 32'(b0.out_valid), 32'h0);
      d0[0] = 32'h1; d0[3] = 32'h33;
      step0(2'd0, 4'b0001, 1'b1, 4'b0001);
      step0(2'd0, 4'b0001, 1'b0, 4'b0000);
      chk("u0 stall data", b0.out_data, 32'h1);
      chk("u0 stall valid", 32'(b0.out_valid), 32'h1);
      step0(2'd3, 4'b1000, 1'b0, 4'b0000);
      chk("u0 stall data sel3", b0.out_data, 32'h1);
      chk("u0 stall src sel3", 32'(b0.out_src), 32'h0);
      step0(2'd3, 4'b1000, 1'b0, 4'b0000);
      chk("u0 stall data 3rd", b0.out_data, 32'h1);
      step0(2'd3, 4'b1000, 1'b1, 4'b1000);
      chk("u0 stall data end", b0.out_data, 32'h1);
      step0(2'd0, 4'b0000, 1'b1, 4'b0000);
      chk("u0 no bubble valid", 32'(b0.out_valid), 32'h1);
      step0(2'd0, 4'b0000, 1'b1, 4'b0000);
      chk("u0 drained valid", 32'(b0.out_valid), 32'h0);
      step2(2'd3, 3'b111, 1'b1, 3'b000);
      step2(2'd3, 3'b111, 1'b1, 3'b000);
      step2(2'd3, 3'b111, 1'b1, 3'b000);
      chk("u2 oor out_valid", 32'(b2.out_valid), 32'h0);
      chk("u2 oor xfer_count", b2.xfer_count, 32'h0);
      step2(2'd2, 3'b100, 1'b1, 3'b100);
      step2(2'd0, 3'b000, 1'b1, 3'b000);
      step2(2'd0, 3'b000, 1'b1, 3'b000);
      chk("u2 xfer_count", b2.xfer_count, 32'h1);
      step1(4'hF, 1'b1, 4'b0001);
      step1(4'hF, 1'b1, 4'b0010);
      step1(4'hF, 1'b1, 4'b0100);
      step1(4'hF, 1'b1, 4'b1000);
      step1(4'hF, 1'b1, 4'b0001);
      d1[1] = 32'h21; d1[3] = 32'h23;
      step1(4'b1010, 1'b1, 4'b0010);
      step1(4'b1010, 1'b0, 4'b0000);
      chk("u1 stall src", 32'(b1.out_src), 32'h1);
      step1(4'b1010, 1'b0, 4'b0000);
      chk("u1 stall src 2", 32'(b1.out_src), 32'h1);
      chk("u1 stall valid", 32'(b1.out_valid), 32'h1);
      step1(4'b1010, 1'b1, 4'b1000);
      step1(4'b1010, 1'b1, 4'b0010);
      step1(4'b1010, 1'b1, 4'b1000);
      step1(4'hF, 1'b1, 4'b0001);
      @(posedge clk); #2;
      reset = 1'b1;
      b1.in_valid = 4'hF; b1.out_ready = 1'b1;
      #1;
      chk("u1 in_ready in reset", 32'(b1.in_ready), 32'h0);
      chk("u1 pending before reset", 32'(b1.out_valid), 32'h1);
      q0.delete(); q1.delete(); q2.delete();
      cnt0 = 0; cnt1 = 0; cnt2 = 0;
      step1(4'hF, 1'b1, 4'b0001);
      chk("u1 valid after reset", 32'(b1.out_valid), 32'h0);
      chk("u1 count after reset", b1.xfer_count, 32'h0);
      chk("u0 count after reset", b0.xfer_count, 32'h0);
      step1(4'h0, 1'b1, 4'b0000);
      chk("u1 count post reset", b1.xfer_count, 32'h1);
      step1(4'h0, 1'b1, 4'b0000);
      chk("u0 leftover", 32'(q0.size()), 32'h0);
      chk("u1 leftover", 32'(q1.size()), 32'h0);
      chk("u2 leftover", 32'(q2.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
